// File: rtl/acc_cpu_param_if.sv
// Purpose: memory-side bus between acc_cpu_param (master) and a synchronous single-port RAM (slave).
// Latency: mem_rdata is valid the cycle after mem_addr is presented; writes land on the clock edge while mem_we is high.
// Backpressure: none, because the RAM always accepts an access every cycle.
// Ports: mem_addr/mem_wdata/mem_we are driven by the CPU; mem_rdata is driven by the RAM.
interface acc_cpu_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_addr, output mem_wdata, output mem_we, input mem_rdata);
    modport slave  (input mem_addr, input mem_wdata, input mem_we, output mem_rdata);
endinterface

// File: rtl/acc_cpu_param.sv
// Purpose: parametrised multicycle single-accumulator CPU with external synchronous RAM.
// Latency: ADD/SUB/LOAD/STORE take 4 cycles; JUMP/JNEG/JZERO/NOP take 3 cycles; HALT is terminal.
// Backpressure: none. The RAM answers every cycle, so the FSM never stalls.
// Ports: clock and reset (async, active-high); mem is the RAM bus (master side).
//        program_counter, acc, instruction_register, flag_z, flag_n and halted are status outputs.
// Optional: define ACC_SAT_EN for saturating two's-complement ADD/SUB and a sticky sat_flag output.
module acc_cpu_param #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    acc_cpu_param_if.master       mem,
    output logic [ADDR_W-1:0]     program_counter,
    output logic [DATA_W-1:0]     acc,
    output logic [DATA_W-1:0]     instruction_register,
    output logic                  flag_z,
    output logic                  flag_n,
    output logic                  halted
`ifdef ACC_SAT_EN
    ,
    output logic                  sat_flag
`endif
);
    localparam int OPC_W = DATA_W - ADDR_W;

    if (OPC_W < 4) begin : g_bad_opc_w
        $error("acc_cpu_param: DATA_W-ADDR_W must be at least 4");
    end

    localparam logic [OPC_W-1:0] OP_ADD   = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_STORE = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_LOAD  = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_JUMP  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_SUB   = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_JNEG  = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_JZERO = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_HALT  = OPC_W'(7);

    typedef enum logic [2:0] {
        S_FETCH_A, S_FETCH, S_DECODE, S_EXEC, S_STORE, S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] ir_q, ir_d;

    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] operand;
    assign opcode  = ir_q[DATA_W-1:ADDR_W];
    assign operand = ir_q[ADDR_W-1:0];

    // ADD/SUB result, shared by both opcodes in S_EXEC
    logic              is_sub;
    logic [DATA_W-1:0] arith_raw;
    logic [DATA_W-1:0] arith_res;
`ifdef ACC_SAT_EN
    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    logic arith_ovf;
    logic sat_q, sat_d;
`endif

    always_comb begin
        is_sub    = (opcode == OP_SUB);
        arith_raw = is_sub ? (acc_q - mem.mem_rdata) : (acc_q + mem.mem_rdata);
`ifdef ACC_SAT_EN
        // Signed overflow: result sign differs from acc, and the operand signs made that impossible
        // without overflow (equal signs for ADD, opposite signs for SUB).
        arith_ovf = (acc_q[DATA_W-1] ^ arith_raw[DATA_W-1]) &
                    (is_sub ? (acc_q[DATA_W-1] ^ mem.mem_rdata[DATA_W-1])
                            : ~(acc_q[DATA_W-1] ^ mem.mem_rdata[DATA_W-1]));
        // On overflow the true result lies beyond the end that acc's sign points to.
        if (arith_ovf) arith_res = acc_q[DATA_W-1] ? SAT_MIN : SAT_MAX;
        else           arith_res = arith_raw;
`else
        arith_res = arith_raw;
`endif
    end

    // FSM: state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_FETCH_A;
        else       state_q <= state_d;
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH_A: state_d = S_FETCH;
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_LOAD: state_d = S_EXEC;
                    OP_STORE:                state_d = S_STORE;
                    OP_HALT:                 state_d = S_HALT;
                    default:                 state_d = S_FETCH_A;
                endcase
            end
            S_EXEC:    state_d = S_FETCH_A;
            S_STORE:   state_d = S_FETCH_A;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_FETCH_A;
        endcase
    end

    // FSM: outputs. mem_we is decoded straight from the state, so an async reset drops it immediately.
    logic [ADDR_W-1:0] mem_addr_c;
    logic              mem_we_c;
    logic              halted_c;
    always_comb begin
        mem_addr_c = pc_q;
        mem_we_c   = 1'b0;
        halted_c   = 1'b0;
        case (state_q)
            S_DECODE, S_EXEC: mem_addr_c = operand;
            S_STORE: begin
                mem_addr_c = operand;
                mem_we_c   = 1'b1;
            end
            S_HALT:  halted_c = 1'b1;
            default: mem_addr_c = pc_q;
        endcase
    end

    // Datapath next values. Branches test acc_q, which is stable throughout S_DECODE.
    always_comb begin
        pc_d  = pc_q;
        acc_d = acc_q;
        ir_d  = ir_q;
`ifdef ACC_SAT_EN
        sat_d = sat_q;
`endif
        case (state_q)
            S_FETCH: begin
                ir_d = mem.mem_rdata;
                pc_d = pc_q + ADDR_W'(1);
            end
            S_DECODE: begin
                case (opcode)
                    OP_JUMP:  pc_d = operand;
                    OP_JNEG:  if (acc_q[DATA_W-1]) pc_d = operand;
                    OP_JZERO: if (acc_q == '0)     pc_d = operand;
                    default:  pc_d = pc_q;
                endcase
            end
            S_EXEC: begin
                case (opcode)
                    OP_ADD, OP_SUB: begin
                        acc_d = arith_res;
`ifdef ACC_SAT_EN
                        if (arith_ovf) sat_d = 1'b1;
`endif
                    end
                    OP_LOAD: acc_d = mem.mem_rdata;
                    default: acc_d = acc_q;
                endcase
            end
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q  <= '0;
            acc_q <= '0;
            ir_q  <= '0;
`ifdef ACC_SAT_EN
            sat_q <= 1'b0;
`endif
        end else begin
            pc_q  <= pc_d;
            acc_q <= acc_d;
            ir_q  <= ir_d;
`ifdef ACC_SAT_EN
            sat_q <= sat_d;
`endif
        end
    end

    assign mem.mem_addr         = mem_addr_c;
    assign mem.mem_we           = mem_we_c;
    assign mem.mem_wdata        = acc_q;
    assign program_counter      = pc_q;
    assign acc                  = acc_q;
    assign instruction_register = ir_q;
    assign flag_z               = (acc_q == '0);
    assign flag_n               = acc_q[DATA_W-1];
    assign halted               = halted_c;
`ifdef ACC_SAT_EN
    assign sat_flag             = sat_q;
`endif
endmodule

// File: doc/acc_cpu_param.md
Name: acc_cpu_param

Overview:
- Parametrised multicycle accumulator CPU. Next generation of the team's 8-bit-address / 16-bit-data single-accumulator processor.
- Data width and address width are configurable, and memory sits outside the block behind a simple synchronous single-port interface.
- Adds SUB, JZERO and HALT instructions, corrects the JNEG sign test, and exports status flags.
- Instantiated at top level next to a single-port synchronous RAM preloaded with program and data.

Parameters:
- DATA_W, 16, accumulator, instruction and memory word width.
- ADDR_W, 8, memory address width and program counter width. OPC_W = DATA_W-ADDR_W must be >= 4.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- mem_addr  out  ADDR_W  RAM address (combinational from state/pc/ir)
- mem_wdata  out  DATA_W  RAM write data, always equal to acc
- mem_we  out  1  RAM write enable
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_addr is presented (synchronous read)
- program_counter  out  ADDR_W  current PC
- acc  out  DATA_W  accumulator
- instruction_register  out  DATA_W  current instruction
- flag_z  out  1  acc == 0
- flag_n  out  1  acc[DATA_W-1]
- halted  out  1  high while in S_HALT

Behaviour:

Instruction format:
- opcode = ir[DATA_W-1:ADDR_W], operand address = ir[ADDR_W-1:0].
- Opcodes: 0 ADD, 1 STORE, 2 LOAD, 3 JUMP, 4 SUB, 5 JNEG, 6 JZERO, 7 HALT.
- Any other value, including nonzero upper opcode bits, is a NOP.

Reset:
- Asynchronous. state=S_FETCH_A, pc=0, acc=0, ir=0, mem_we=0, halted=0.
- Reset asserted mid-instruction aborts it; a STORE in progress does not write on that edge.

States and per-cycle actions:
- S_FETCH_A: mem_addr=pc. Next S_FETCH.
- S_FETCH: ir<=mem_rdata; pc<=pc+1, wrapping modulo 2^ADDR_W. mem_addr=pc. Next S_DECODE.
- S_DECODE: mem_addr=operand.
  - ADD/SUB/LOAD -> S_EXEC.
  - STORE -> S_STORE.
  - JUMP: pc<=operand.
  - JNEG: pc<=operand if acc[DATA_W-1]==1.
  - JZERO: pc<=operand if acc==0.
  - Jumps and NOP then -> S_FETCH_A.
  - HALT -> S_HALT.
- S_EXEC: mem_addr=operand. ADD: acc<=acc+mem_rdata. SUB: acc<=acc-mem_rdata. LOAD: acc<=mem_rdata. Next S_FETCH_A.
- S_STORE: mem_addr=operand, mem_we=1, mem_wdata=acc. Next S_FETCH_A.
- S_HALT: halted=1, mem_we=0, mem_addr=pc. Stays here until reset.

Latency:
- ADD/SUB/LOAD/STORE: 4 cycles.
- JUMP/JNEG/JZERO/NOP: 3 cycles.
- HALT: terminal.

Arithmetic:
- ADD/SUB wrap modulo 2^DATA_W; overflow is silently discarded (unless ACC_SAT_EN).
- Flags are combinational from acc.

Other rules:
- mem_we is high only in S_STORE.
- Branch conditions use the acc value at the start of S_DECODE.
- Self-modifying code is allowed: a STORE to a not-yet-fetched address is seen by the later fetch.
- Jump target equal to the current instruction address produces a legal infinite loop.

Optional Feature:
- Macro: ACC_SAT_EN.
- Defined:
  - ADD/SUB saturate as two's complement: result clamps to 2^(DATA_W-1)-1 or -2^(DATA_W-1) on signed overflow.
  - Extra output sat_flag (1 bit) is set in the S_EXEC cycle that saturates. It is sticky until reset.
- Undefined: wrap-around arithmetic, no sat_flag port.

Test Plan (DATA_W=16, ADDR_W=8 unless stated):
1. Reset behaviour. Program LOAD 0x10, ADD 0x11, STORE 0x12, HALT, with mem[0x10]=5, mem[0x11]=7. Required: mem[0x12]=12, halted=1 after exactly 4+4+4+3 cycles from reset release, pc=4. Reset mid-run returns pc=0 and acc=0 immediately.
2. Branches. LOAD of 0xFFFF then JNEG 0x20 -> pc=0x20; acc=0x0001 does not branch. LOAD 0 then JZERO 0x30 -> pc=0x30. JUMP 0x05 from address 0x05 keeps pc cycling 0x05/0x06.
3. Wrap-around. JUMP 0xFF where mem[0xFF] is a NOP -> next fetch from 0x00. ADD 0x8000+0x8000 -> acc=0, flag_z=1.
4. SUB and flags. acc=3, SUB of 5 -> acc=0xFFFE, flag_n=1. Undefined opcode 0x0F executes as NOP in 3 cycles with acc unchanged.
5. Reset during S_STORE. Asserting reset in that cycle leaves the target word unwritten and mem_we=0 asynchronously.
6. ACC_SAT_EN defined. 0x7FFF+1 -> acc=0x7FFF, sat_flag=1. 0x8000-1 -> acc=0x8000. Also rerun scenario 1 with DATA_W=24, ADDR_W=10.
